pulse_stretcher: RTL and testbench
==================================

Name: pulse_stretcher

Overview:
Converts single-cycle event pulses into human-visible level flashes, for example to drive an LED. It is the output-direction counterpart of the key-to-pulse single pulser: it takes the clock-synchronous one-cycle pulse that block produces and turns it back into a timed level. Rapid pulses are queued in a saturating pending counter, so each event gets its own flash and none is silently merged. It sits between event sources (pulsers, counters, FSM strobes) and board LEDs or other slow indicators.

Parameters:
ON_CYCLES, 4, clock cycles level_o is held high per flash; legal range 1 or more.
GAP_CYCLES, 2, clock cycles level_o is held low between consecutive flashes; legal range 1 or more.
MAX_PENDING, 3, maximum number of queued flashes; legal range 1 or more.
CNT_W, 32, width of the internal phase counter; must hold max(ON_CYCLES, GAP_CYCLES)-1.
PEND_W, 2, width of pending_o; must hold MAX_PENDING.

Ports:
clk_i  input  1  system clock; all state changes on its rising edge.
rst_ni  input  1  asynchronous, active-low reset.
pulse_i  input  1  event strobe, clock-synchronous; each cycle it is high counts as one event.
clear_i  input  1  synchronous clear of the pending count and overflow flag.
level_o  output  1  stretched flash output, registered.
busy_o  output  1  high while a flash or gap is in progress, registered.
pending_o  output  PEND_W  number of queued flashes not yet started.
overflow_o  output  1  sticky; set when an event was dropped because the queue was full.

Behaviour:
- Reset: one clock and one reset only; the reset is asynchronous and active-low. While rst_ni is low:
  - state = IDLE;
  - level_o = 0, busy_o = 0, pending_o = 0, overflow_o = 0, counter = 0.
  - Reset asserted mid-flash aborts the flash immediately; no residual flash runs after release.
- States: IDLE, ON, GAP.
  - busy_o = (state != IDLE).
  - level_o = (state == ON).
  - All outputs come directly from flops; there are no combinational input-to-output paths.
- IDLE:
  - pulse_i=1 sampled at edge k: state becomes ON and counter loads ON_CYCLES-1.
  - level_o is high during the ON_CYCLES cycles following edge k (latency 1 cycle).
  - pending_o does not change.
- ON:
  - Counter decrements each cycle.
  - At counter==0: state becomes GAP and counter loads GAP_CYCLES-1.
- GAP:
  - Counter decrements each cycle.
  - At counter==0 with pending>0 (after this cycle's enqueue is counted): state becomes ON, counter loads ON_CYCLES-1, pending decrements.
  - At counter==0 with pending==0: state becomes IDLE.
  - The next flash therefore starts exactly GAP_CYCLES low cycles after the previous one ends.
- Enqueue: pulse_i=1 while in ON or GAP:
  - pending < MAX_PENDING: pending increments.
  - pending == MAX_PENDING: pending is unchanged and overflow_o is set.
- Enqueue and dequeue in the same cycle: net pending is unchanged. This includes pending==MAX_PENDING; that case does not set overflow.
- clear_i=1:
  - Next cycle pending=0 and overflow=0.
  - The flash or gap in progress completes normally.
  - A pulse_i in the same cycle as clear_i is dropped, unless state is IDLE, where it starts a flash.
- Width rules: pending arithmetic saturates at both ends and never wraps. The counter never underflows.

Decomposition:
- Shared package pulse_stretcher_pkg holds:
  - the state encoding constants (IDLE=2'd0, ON=2'd1, GAP=2'd2);
  - the default ON_CYCLES, GAP_CYCLES and MAX_PENDING constants for board builds.
- One natural sub-module, phase_counter: a loadable down-counter with a load value input and a zero flag. It is reused for both the ON and GAP phases.
- The FSM and the pending logic stay in the top module.

Test Plan:
1. Single pulse at cycle 0 (ON=4, GAP=2) -> level_o=1 on cycles 1-4, 0 from cycle 5; busy_o=1 on cycles 1-6, 0 at cycle 7; pending_o stays 0.
2. Pulses at cycles 0 and 1 -> level_o high 1-4, low 5-6, high 7-10; pending_o=1 during cycles 2-6, then 0.
3. Five back-to-back pulses (cycles 0-4, MAX_PENDING=3) -> pending_o reaches 3, overflow_o=1 from cycle 5; exactly 4 flashes total, then busy_o=0.
4. pending=1 and pulse_i on the final GAP cycle -> the next flash starts, pending_o stays 1, overflow_o stays 0.
5. rst_ni low at cycle 2 of a flash, with pending=2 -> level_o, busy_o and pending_o are 0 immediately (before the next edge); after release a new pulse gives a normal 4-cycle flash.
6. clear_i at cycle 2, with pending=2 and overflow=1 -> both are 0 at cycle 3; the current flash ends at cycle 4, then a 2-cycle gap, then IDLE.

Source files
------------

// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the pulse stretcher.
//   state_e           : FSM state encoding (IDLE, ON, GAP)
//   DefaultOnCycles   : board-build flash length in clock cycles
//   DefaultGapCycles  : board-build low time between flashes in clock cycles
//   DefaultMaxPending : board-build depth of the flash queue
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOn   = 2'd1,
        StGap  = 2'd2
    } state_e;

    localparam int unsigned DefaultOnCycles   = 4;
    localparam int unsigned DefaultGapCycles  = 2;
    localparam int unsigned DefaultMaxPending = 3;

endpackage

// File: rtl/pulse_stretcher_phase_counter.sv
// Loadable down-counter used to time both the ON and GAP phases.
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset, clears the count
//   load_i     : load load_val_i on the next edge (has priority over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement on the next edge; holds at zero, never underflows
//   zero_o     : count is zero
module pulse_stretcher_phase_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into timed level flashes (e.g. for an LED).
// Pulses arriving during a flash or gap are queued in a saturating pending count
// so that every event gets its own flash.
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset
//   pulse_i    : event strobe, one event per high cycle
//   clear_i    : synchronous clear of pending count and overflow flag
//   level_o    : registered flash output
//   busy_o     : registered, high during a flash or the gap after it
//   pending_o  : number of queued flashes not yet started
//   overflow_o : sticky, an event was dropped because the queue was full
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int unsigned ON_CYCLES   = DefaultOnCycles,
    parameter int unsigned GAP_CYCLES  = DefaultGapCycles,
    parameter int unsigned MAX_PENDING = DefaultMaxPending,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned PEND_W      = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              pulse_i,
    input  logic              clear_i,
    output logic              level_o,
    output logic              busy_o,
    output logic [PEND_W-1:0] pending_o,
    output logic              overflow_o
);

    localparam logic [CNT_W-1:0]  OnLoad  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GapLoad = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PendMax = PEND_W'(MAX_PENDING);

    state_e            state_q, state_d;
    logic              level_q, busy_q;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;

    logic              cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              enq, deq;

    pulse_stretcher_phase_counter #(
        .CNT_W (CNT_W)
    ) u_phase_counter (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Phase sequencing and counter control.
    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = OnLoad;
        enq          = 1'b0;
        deq          = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A pulse in IDLE starts a flash directly; it is never queued.
                if (pulse_i) begin
                    state_d  = StOn;
                    cnt_load = 1'b1;
                end
            end
            StOn: begin
                enq = pulse_i && !clear_i;
                if (cnt_zero) begin
                    state_d      = StGap;
                    cnt_load     = 1'b1;
                    cnt_load_val = GapLoad;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StGap: begin
                enq = pulse_i && !clear_i;
                if (cnt_zero) begin
                    // This cycle's enqueue counts, so a pulse on the last gap
                    // cycle can start the next flash even with an empty queue.
                    // A clear empties the queue first, so no flash follows it.
                    if (!clear_i && ((pend_q != '0) || enq)) begin
                        state_d  = StOn;
                        cnt_load = 1'b1;
                        deq      = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Pending queue count: saturating at both ends, overflow is sticky.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (clear_i) begin
            pend_d = '0;
            ovf_d  = 1'b0;
        end else if (enq && !deq) begin
            if (pend_q == PendMax) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (deq && !enq) begin
            if (pend_q != '0) begin
                pend_d = pend_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= (state_d == StOn);
            busy_q  <= (state_d != StIdle);
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign level_o    = level_q;
    assign busy_o     = busy_q;
    assign pending_o  = pend_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
module tb_pulse_stretcher;

    localparam int ON   = 4;
    localparam int GAP  = 2;
    localparam int MAXP = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pulse_i = 1'b0;
    logic       clear_i = 1'b0;
    logic       level_o;
    logic       busy_o;
    logic [1:0] pending_o;
    logic       overflow_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    pulse_stretcher #(
        .ON_CYCLES   (ON),
        .GAP_CYCLES  (GAP),
        .MAX_PENDING (MAXP),
        .CNT_W       (32),
        .PEND_W      (2)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .pulse_i    (pulse_i),
        .clear_i    (clear_i),
        .level_o    (level_o),
        .busy_o     (busy_o),
        .pending_o  (pending_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // Schedule model: a flash occupies cycles [m_start, m_start+ON+GAP-1], of which
    // the first ON are high. Cycle n's inputs are applied at the edge ending cycle n.
    int m_cyc    = 0;
    bit m_active = 1'b0;
    int m_start  = 0;
    int m_pend   = 0;
    bit m_ovf    = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_pend   = 0;
            m_ovf    = 1'b0;
        end else begin
            int n, last, enq;
            bit deq;
            n = m_cyc;
            if (!m_active) begin
                if (pulse_i) begin
                    m_active = 1'b1;
                    m_start  = n + 1;
                end
                if (clear_i) begin
                    m_pend = 0;
                    m_ovf  = 1'b0;
                end
            end else begin
                last = m_start + ON + GAP - 1;
                if (clear_i) begin
                    m_pend = 0;
                    m_ovf  = 1'b0;
                    if (n == last) m_active = 1'b0;
                end else begin
                    enq = pulse_i ? 1 : 0;
                    deq = (n == last) && (m_pend + enq > 0);
                    if (enq == 1 && !deq) begin
                        if (m_pend == MAXP) m_ovf = 1'b1;
                        else m_pend = m_pend + 1;
                    end else if (deq && enq == 0) begin
                        m_pend = m_pend - 1;
                    end
                    if (n == last) begin
                        if (deq) m_start = n + 1;
                        else m_active = 1'b0;
                    end
                end
            end
        end
        m_cyc++;
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_level", int'(level_o), (m_active && (m_cyc - m_start) < ON) ? 1 : 0);
            chk("model_busy", int'(busy_o), m_active ? 1 : 0);
            chk("model_pending", int'(pending_o), m_pend);
            chk("model_overflow", int'(overflow_o), m_ovf ? 1 : 0);
        end
    end

    // Apply inputs for the next cycle; on return the current cycle's outputs are stable.
    task automatic tick(input bit p, input bit c);
        @(negedge clk);
        pulse_i = p;
        clear_i = c;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((busy_o || level_o) && k < 60) begin
            tick(1'b0, 1'b0);
            k++;
        end
        chk("drain_idle", int'(busy_o), 0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
    endtask

    initial begin
        int flashes;
        bit prev;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_level", int'(level_o), 0);
        chk("reset_busy", int'(busy_o), 0);
        chk("reset_pending", int'(pending_o), 0);
        chk("reset_overflow", int'(overflow_o), 0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        tick(1'b0, 1'b0);

        // 1: single pulse
        for (int i = 0; i < 10; i++) begin
            tick(i == 0, 1'b0);
            if (i == 1) chk("t1_level_c1", int'(level_o), 1);
            if (i == 4) chk("t1_level_c4", int'(level_o), 1);
            if (i == 5) chk("t1_level_c5", int'(level_o), 0);
            if (i == 6) chk("t1_busy_c6", int'(busy_o), 1);
            if (i == 7) chk("t1_busy_c7", int'(busy_o), 0);
            if (i == 3) chk("t1_pending", int'(pending_o), 0);
        end
        drain();

        // 2: two back-to-back pulses
        for (int i = 0; i < 13; i++) begin
            tick(i < 2, 1'b0);
            if (i == 4)  chk("t2_level_c4", int'(level_o), 1);
            if (i == 5)  chk("t2_level_c5", int'(level_o), 0);
            if (i == 6)  chk("t2_level_c6", int'(level_o), 0);
            if (i == 7)  chk("t2_level_c7", int'(level_o), 1);
            if (i == 10) chk("t2_level_c10", int'(level_o), 1);
            if (i == 11) chk("t2_level_c11", int'(level_o), 0);
            if (i == 2)  chk("t2_pending_c2", int'(pending_o), 1);
            if (i == 6)  chk("t2_pending_c6", int'(pending_o), 1);
            if (i == 7)  chk("t2_pending_c7", int'(pending_o), 0);
        end
        drain();

        // 3: five pulses, queue saturates, one event dropped
        flashes = 0;
        prev    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(i < 5, 1'b0);
            if (i == 5) begin
                chk("t3_pending_c5", int'(pending_o), 3);
                chk("t3_overflow_c5", int'(overflow_o), 1);
            end
            if (level_o && !prev) flashes++;
            prev = level_o;
        end
        chk("t3_flashes", flashes, 4);
        chk("t3_busy_end", int'(busy_o), 0);
        chk("t3_overflow_end", int'(overflow_o), 1);
        drain();

        // 4: enqueue and dequeue on the final gap cycle
        for (int i = 0; i < 13; i++) begin
            tick(i == 0 || i == 1 || i == 6, 1'b0);
            if (i == 6) chk("t4_pending_c6", int'(pending_o), 1);
            if (i == 7) begin
                chk("t4_pending_c7", int'(pending_o), 1);
                chk("t4_overflow_c7", int'(overflow_o), 0);
                chk("t4_level_c7", int'(level_o), 1);
            end
        end
        drain();

        // 5: asynchronous reset mid-flash with pending=2
        for (int i = 0; i < 4; i++) begin
            tick(i < 3, 1'b0);
            if (i == 3) chk("t5_pending_pre", int'(pending_o), 2);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_level", int'(level_o), 0);
        chk("t5_rst_busy", int'(busy_o), 0);
        chk("t5_rst_pending", int'(pending_o), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        flashes = 0;
        prev    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(i == 0, 1'b0);
            if (i == 0) chk("t5_post_busy_c0", int'(busy_o), 0);
            if (i == 1) chk("t5_post_level_c1", int'(level_o), 1);
            if (i == 4) chk("t5_post_level_c4", int'(level_o), 1);
            if (i == 5) chk("t5_post_level_c5", int'(level_o), 0);
            if (level_o && !prev) flashes++;
            prev = level_o;
        end
        chk("t5_post_flashes", flashes, 1);
        drain();

        // 6: clear during the second flash with pending=2, overflow=1
        for (int i = 0; i < 16; i++) begin
            tick(i < 5, i == 8);
            if (i == 8) begin
                chk("t6_pending_c8", int'(pending_o), 2);
                chk("t6_overflow_c8", int'(overflow_o), 1);
            end
            if (i == 9) begin
                chk("t6_pending_c9", int'(pending_o), 0);
                chk("t6_overflow_c9", int'(overflow_o), 0);
            end
            if (i == 10) chk("t6_level_c10", int'(level_o), 1);
            if (i == 11) chk("t6_level_c11", int'(level_o), 0);
            if (i == 12) chk("t6_busy_c12", int'(busy_o), 1);
            if (i == 13) chk("t6_busy_c13", int'(busy_o), 0);
        end
        drain();

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
